// File: rtl/ula_sequencial_param.sv
// rtl/ula_sequencial_param.sv - sequential ALU with valid/ready handshake and z/c/v/n/err flags.
// Optional macro ULA_MUL_EN adds op 8: unsigned shift-and-add multiply, one multiplier bit per cycle.
module ula_sequencial_param #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_n,
   output logic             flag_err
);

   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] W_AMT = WIDTH'(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic             live_q;
   logic [WIDTH-1:0] s_q, s_d;
   logic             z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d, err_q, err_d;

   logic [WIDTH:0]     add_w, sub_w;
   logic [2*WIDTH-1:0] shl_w, shr_w;
   logic               sh_ok;
   logic [WIDTH-1:0]   alu_s;
   logic               alu_c, alu_v, alu_err;

   assign add_w = {1'b0, a} + {1'b0, b};
   assign sub_w = {1'b0, a} - {1'b0, b};
   // Shifting inside a double-width window keeps the last bit pushed out at index WIDTH / WIDTH-1.
   assign shl_w = {{WIDTH{1'b0}}, a} << b;
   assign shr_w = {a, {WIDTH{1'b0}}} >> b;
   assign sh_ok = (b != '0) && (b <= W_AMT);

`ifdef ULA_MUL_EN
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   mca_q, mca_d;
   logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
   logic [WIDTH:0]     upper_sum;
   logic [CW-1:0]      cnt_q, cnt_d;

   // Multiplier sits in the low half and is consumed LSB first while partial sums shift in from the top.
   assign upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mca_q} : '0);
   assign prod_step = {upper_sum, prod_q[MSB:1]};
`endif

   always_comb begin
      alu_s   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op)
         4'd0: begin
            alu_s = add_w[MSB:0];
            alu_c = add_w[WIDTH];
            alu_v = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
         end
         4'd1: begin
            alu_s = sub_w[MSB:0];
            alu_c = sub_w[WIDTH];
            alu_v = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
         end
         4'd2: begin
            alu_s = shl_w[MSB:0];
            alu_c = sh_ok & shl_w[WIDTH];
         end
         4'd3: begin
            alu_s = shr_w[2*WIDTH-1:WIDTH];
            alu_c = sh_ok & shr_w[MSB];
         end
         4'd4: alu_s = a & b;
         4'd5: alu_s = a | b;
         4'd6: alu_s = a ^ b;
         4'd7: alu_s = ~a;
         default: alu_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      z_d     = z_q;
      c_d     = c_q;
      v_d     = v_q;
      n_d     = n_q;
      err_d   = err_q;
`ifdef ULA_MUL_EN
      mca_d   = mca_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
`endif
      in_ready  = (state_q == IDLE) && live_q;
      out_valid = (state_q == DONE);
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
`ifdef ULA_MUL_EN
               if (op == 4'd8) begin
                  state_d = BUSY;
                  mca_d   = a;
                  prod_d  = {{WIDTH{1'b0}}, b};
                  cnt_d   = '0;
               end else
`endif
               begin
                  state_d = DONE;
                  s_d     = alu_s;
                  c_d     = alu_c;
                  v_d     = alu_v;
                  err_d   = alu_err;
               end
            end
         end
         BUSY: begin
`ifdef ULA_MUL_EN
            prod_d = prod_step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               s_d     = prod_step[MSB:0];
               c_d     = |prod_step[2*WIDTH-1:WIDTH];
               v_d     = 1'b0;
               err_d   = 1'b0;
            end
`else
            state_d = IDLE;
`endif
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d == DONE && state_q != DONE) begin
         z_d = (s_d == '0);
         n_d = s_d[MSB];
      end
   end

   // live_q keeps in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         live_q  <= 1'b0;
         s_q     <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         n_q     <= 1'b0;
         err_q   <= 1'b0;
`ifdef ULA_MUL_EN
         mca_q   <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
         s_q     <= s_d;
         z_q     <= z_d;
         c_q     <= c_d;
         v_q     <= v_d;
         n_q     <= n_d;
         err_q   <= err_d;
`ifdef ULA_MUL_EN
         mca_q   <= mca_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign s        = s_q;
   assign flag_z   = z_q;
   assign flag_c   = c_q;
   assign flag_v   = v_q;
   assign flag_n   = n_q;
   assign flag_err = err_q;

endmodule

// File: tb/tb_ula_sequencial_param.sv
// tb/tb_ula_sequencial_param.sv - scoreboard bench for ula_sequencial_param (WIDTH = 8).
module tb_ula_sequencial_param;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         flag_z, flag_c, flag_v, flag_n, flag_err;

   ula_sequencial_param #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s),
      .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_err(flag_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic [4:0]   f;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] flags_now();
      return {flag_err, flag_n, flag_v, flag_c, flag_z};
   endfunction

   // Reference model in plain integer arithmetic; flags packed as {err, n, v, c, z}.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      int   ux, uy, sx, sy, r, sr;
      logic c, v, err;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 128) ? ux - 256 : ux;
      sy = (uy >= 128) ? uy - 256 : uy;
      c = 1'b0; v = 1'b0; err = 1'b0; r = 0;
      e.lat = 1;
      case (o)
         4'd0: begin r = ux + uy; c = (r > 255); sr = sx + sy; v = (sr > 127) || (sr < -128); end
         4'd1: begin r = ux - uy; c = (ux < uy); sr = sx - sy; v = (sr > 127) || (sr < -128); end
         4'd2: begin
            r = (uy >= W) ? 0 : (ux << uy);
            c = (uy >= 1 && uy <= W) ? 1'((ux >> (W - uy)) & 1) : 1'b0;
         end
         4'd3: begin
            r = (uy >= W) ? 0 : (ux >> uy);
            c = (uy >= 1 && uy <= W) ? 1'((ux >> (uy - 1)) & 1) : 1'b0;
         end
         4'd4: r = ux & uy;
         4'd5: r = ux | uy;
         4'd6: r = ux ^ uy;
         4'd7: r = 255 - ux;
`ifdef ULA_MUL_EN
         4'd8: begin r = ux * uy; c = (r > 255); e.lat = W + 1; end
`endif
         default: begin r = 0; err = 1'b1; end
      endcase
      e.s = W'(r & 255);
      e.f = {err, e.s[W-1], v, c, (e.s == '0)};
      return e;
   endfunction

   task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
      exp_t e;
      int   lat;
      int   wc;
      string t;
      t = $sformatf("op%0d a=%02h b=%02h", o, x, y);
      wc = 0;
      while (!in_ready && wc < 20) begin tick(); wc++; end
      check({t, " in_ready"}, 32'(in_ready), 32'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      sb_q.push_back(model(o, x, y));
      tick();
      in_valid = 1'b0;
      op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin tick(); lat++; end
      check({t, " out_valid"}, 32'(out_valid), 32'd1);
      if (sb_q.size() == 0) begin
         check({t, " scoreboard"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({t, " latency"}, 32'(lat), 32'(e.lat));
         check({t, " s"}, 32'(s), 32'(e.s));
         check({t, " flags"}, 32'(flags_now()), 32'(e.f));
         for (int i = 0; i < hold; i++) begin
            tick();
            check({t, " hold s/flags/valid/ready"}, {19'd0, out_valid, in_ready, flags_now(), s},
                  {19'd0, 1'b1, 1'b0, e.f, e.s});
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({t, " idle after consume"}, {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      #1;
      check("reset outputs", {19'd0, out_valid, in_ready, flags_now(), s}, 32'd0);
      tick(); tick();
      check("reset ready held low", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      check("ready before first edge", 32'(in_ready), 32'd0);
      tick();
      check("ready after release", 32'(in_ready), 32'd1);

      run_op(4'd0, 8'hFF, 8'h01, 0);
      run_op(4'd1, 8'h80, 8'h01, 0);
      run_op(4'd1, 8'h01, 8'h02, 0);
      run_op(4'd2, 8'h81, 8'd1, 0);
      run_op(4'd3, 8'h0F, 8'd9, 0);
      run_op(4'd2, 8'h81, 8'd8, 0);
      run_op(4'd3, 8'h81, 8'd8, 0);
      run_op(4'd2, 8'hFF, 8'd0, 0);
      run_op(4'd0, 8'h7F, 8'h01, 1);
      run_op(4'd6, 8'hAA, 8'hFF, 5);
      run_op(4'd7, 8'h00, 8'h00, 0);
      run_op(4'd8, 8'h10, 8'h11, 2);
      run_op(4'd15, 8'h12, 8'h34, 0);
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] rb;
         rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
         run_op(4'($urandom_range(0, 15)), W'($urandom), rb, $urandom_range(0, 2));
      end

      // Reset on the third cycle after acceptance must discard the operation in flight.
`ifdef ULA_MUL_EN
      op = 4'd8;
`else
      op = 4'd0;
`endif
      a = 8'h03; b = 8'h04; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("abort outputs", {29'd0, out_valid, in_ready, 1'b0}, 32'd0);
      check("abort s", 32'(s), 32'd0);
      check("abort flags", 32'(flags_now()), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check("no result after abort", 32'(seen), 32'd0);
      check("ready after abort", 32'(in_ready), 32'd1);

      run_op(4'd4, 8'hF0, 8'h3C, 0);
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ula_sequencial_param.md
ULA_SEQUENCIAL_PARAM -- requirements
Module: ula_sequencial_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous, active-low reset (one clock domain, one reset; fixed).
REQ-004 SHALL have ports: in_valid  in  1  operation request; in_ready  out  1  block can accept request.
REQ-005 SHALL have ports: op  in  4  operation code; a, b  in  WIDTH  operands (unsigned, two's-complement for overflow).
REQ-006 SHALL have ports: out_valid  out  1  result available; out_ready  in  1  consumer accepts result.
REQ-007 SHALL have ports: s  out  WIDTH  result; flag_z, flag_c, flag_v, flag_n, flag_err  out  1 each  zero, carry/borrow, signed overflow, negative, illegal op.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-009 SHALL accept a request (latch op, a, b) on a clk edge with in_valid && in_ready; inputs ignored otherwise.
REQ-010 SHALL decode op: 0 a+b, 1 a-b, 2 a<<b, 3 a>>b (logical), 4 a&b, 5 a|b, 6 a^b, 7 ~a; results truncated to WIDTH.
REQ-011 SHALL for shifts treat b as unsigned; b >= WIDTH yields s = 0.
REQ-012 SHALL, for ops 0-7 and illegal ops, transition IDLE->DONE on acceptance; result visible the next cycle (latency 1).
REQ-013 SHALL hold s and all flags stable in DONE until out_valid && out_ready, then go DONE->IDLE on that edge.
REQ-014 SHALL set flag_c: op0 carry-out of bit WIDTH-1; op1 borrow (1 when a < b unsigned); op2 last bit shifted out of MSB end, op3 last bit shifted out of LSB end (0 when b = 0 or b > WIDTH); 0 otherwise.
REQ-015 SHALL set flag_v on signed overflow for op0/op1 only; 0 otherwise.
REQ-016 SHALL set flag_z = (s == 0) and flag_n = s[WIDTH-1] for every completed operation, including illegal.
REQ-017 SHALL treat op 9-15 (and op 8 without the macro) as illegal: s = 0, flag_err = 1, flag_z = 1, other flags 0.
REQ-018 SHALL never issue a second result before the first is consumed; back-pressure via out_ready stalls indefinitely without data loss.
REQ-019 SHALL drive in_ready = 0 in BUSY and DONE, so simultaneous in_valid with out_valid && out_ready is not accepted until the following IDLE cycle.

Reset
REQ-020 SHALL on rst_n = 0 asynchronously enter IDLE and force s = 0, all flags 0, out_valid = 0, in_ready = 1 while rst_n low? no: in_ready = 0 while rst_n low, 1 from first edge after release.
REQ-021 SHALL abort any operation in BUSY or DONE on reset; the aborted result is never presented.

Configuration
REQ-022 SHALL, when macro ULA_MUL_EN is defined, implement op 8 = unsigned multiply a*b, low WIDTH bits in s, flag_c = 1 if any high-half bit nonzero.
REQ-023 SHALL compute op 8 by shift-and-add in BUSY, one multiplier bit per cycle: IDLE->BUSY on acceptance, exactly WIDTH cycles in BUSY, then DONE (latency WIDTH+1).
REQ-024 SHALL, without ULA_MUL_EN, contain no multiply logic, never enter BUSY, and report op 8 as illegal per REQ-017.

Verification (WIDTH = 8)
REQ-025 SHALL cover add wrap: op0, a=0xFF, b=0x01 -> s=0x00, z=1, c=1, v=0, out_valid one cycle after acceptance.
REQ-026 SHALL cover signed overflow/borrow: op1, a=0x80, b=0x01 -> s=0x7F, v=1, c=0, n=0; op1, a=0x01, b=0x02 -> s=0xFF, c=1, n=1.
REQ-027 SHALL cover shifts: op2, a=0x81, b=1 -> s=0x02, c=1; op3, a=0x0F, b=9 -> s=0x00, z=1, c=0.
REQ-028 SHALL cover back-pressure: op6, a=0xAA, b=0xFF, out_ready=0 for 5 cycles -> s=0x55 held, in_ready=0 throughout; release -> IDLE next cycle.
REQ-029 SHALL cover multiply (ULA_MUL_EN): op8, a=0x10, b=0x11 -> s=0x10, c=1 after exactly 9 cycles; without macro -> s=0, err=1 after 1 cycle.
REQ-030 SHALL cover reset mid-BUSY: assert rst_n=0 on cycle 3 of op8 -> out_valid=0, s=0 immediately; no result after release.
